// File: rtl/secuenciador_sumador_pkg.sv
// Shared encodings for the sumador8 command sequencer: sumador8 MODO codes,
// sequencer state codes, the legal NBYTES range and the command legality rule.
package secuenciador_sumador_pkg;

    localparam logic [1:0] MODO_HOLD  = 2'b00;
    localparam logic [1:0] MODO_SUMA  = 2'b01;
    localparam logic [1:0] MODO_RESTA = 2'b10;
    localparam logic [1:0] MODO_CLR   = 2'b11;

    localparam logic [2:0] S_RESET   = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam int NBYTES_MIN = 1;
    localparam int NBYTES_MAX = 4;

    // Only add and sub reach the adder; the other two codes are reported as errors.
    function automatic logic op_legal(input logic [1:0] op);
        return (op == MODO_SUMA) || (op == MODO_RESTA);
    endfunction

endpackage

// File: rtl/secuenciador_sumador_selector_byte.sv
// Byte-lane multiplexer: returns byte i_sel of an NBYTES-wide word.
// Out-of-range selects return zero.
module secuenciador_sumador_selector_byte #(
    parameter int NBYTES = 2,
    parameter int KW     = 1
) (
    input  logic [8*NBYTES-1:0] i_word,
    input  logic [KW-1:0]       i_sel,
    output logic [7:0]          o_byte
);

    always_comb begin
        // NOTE: the default before the loop keeps every path assigned, so no latch is inferred.
        o_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (i_sel == KW'(i)) begin
                o_byte = i_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/secuenciador_sumador.sv
// Command sequencer for sumador8: splits one NBYTES-wide add/sub into byte
// operations, LSB first, chaining the carry/borrow, and returns the full result.
module secuenciador_sumador
    import secuenciador_sumador_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [1:0]          i_cmd_op,
    input  logic [8*NBYTES-1:0] i_cmd_a,
    input  logic [8*NBYTES-1:0] i_cmd_b,
    output logic                o_enb,
    output logic [1:0]          o_modo,
    output logic [7:0]          o_a,
    output logic [7:0]          o_b,
    output logic                o_rci,
    input  logic [7:0]          i_q,
    input  logic                i_rco,
    output logic                o_res_valid,
    input  logic                i_res_ready,
    output logic [8*NBYTES-1:0] o_res_q,
    output logic                o_res_co,
    output logic                o_res_err
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX) begin : g_nbytes_check
        $error("secuenciador_sumador: NBYTES must be in 1..4");
    end

    logic [2:0]    r_state;
    logic [1:0]    r_op;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [KW-1:0] r_k;
    logic          r_carry;
    logic [W-1:0]  r_res_q;
    logic          r_res_co;
    logic          r_res_err;

    logic          w_accept;
    logic          w_last;
    logic [7:0]    w_a_byte;
    logic [7:0]    w_b_byte;

    assign w_accept = (r_state == S_IDLE) && i_cmd_valid;
    assign w_last   = (r_k == KW'(NBYTES - 1));

    secuenciador_sumador_selector_byte #(.NBYTES(NBYTES), .KW(KW)) u_sel_a (
        .i_word (r_a),
        .i_sel  (r_k),
        .o_byte (w_a_byte)
    );

    secuenciador_sumador_selector_byte #(.NBYTES(NBYTES), .KW(KW)) u_sel_b (
        .i_word (r_b),
        .i_sel  (r_k),
        .o_byte (w_b_byte)
    );

    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with <= so every register sees pre-edge values of the others.
        if (i_rst) begin
            r_state   <= S_RESET;
            r_op      <= MODO_HOLD;
            r_a       <= '0;
            r_b       <= '0;
            r_k       <= '0;
            r_carry   <= 1'b0;
            r_res_q   <= '0;
            r_res_co  <= 1'b0;
            r_res_err <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_IDLE;
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= i_cmd_op;
                        r_a       <= i_cmd_a;
                        r_b       <= i_cmd_b;
                        r_k       <= '0;
                        r_carry   <= 1'b0;
                        r_res_q   <= '0;
                        r_res_co  <= 1'b0;
                        r_res_err <= !op_legal(i_cmd_op);
                        r_state   <= op_legal(i_cmd_op) ? S_ISSUE : S_RESP;
                    end
                end
                S_ISSUE: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    // sumador8 registered this byte at the previous edge; its Q/RCO are valid now.
                    for (int i = 0; i < NBYTES; i++) begin
                        if (r_k == KW'(i)) begin
                            r_res_q[8*i +: 8] <= i_q;
                        end
                    end
                    r_carry <= i_rco;
                    if (w_last) begin
                        r_res_co <= i_rco;
                        r_state  <= S_RESP;
                    end else begin
                        r_k     <= r_k + 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_RESP: begin
                    if (i_res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        o_enb       = 1'b0;
        o_modo      = MODO_HOLD;
        o_a         = 8'h00;
        o_b         = 8'h00;
        o_rci       = 1'b0;
        o_cmd_ready = 1'b0;
        o_res_valid = 1'b0;
        case (r_state)
            S_RESET: begin
                o_enb  = 1'b1;
                o_modo = MODO_CLR;
            end
            S_IDLE: o_cmd_ready = 1'b1;
            S_ISSUE: begin
                o_enb  = 1'b1;
                o_modo = r_op;
                o_a    = w_a_byte;
                o_b    = w_b_byte;
                o_rci  = r_carry;
            end
            S_RESP: o_res_valid = 1'b1;
            default: ;
        endcase
    end

    assign o_res_q   = r_res_q;
    assign o_res_co  = r_res_co;
    assign o_res_err = r_res_err;

endmodule
